// File: rtl/im2col_pkg.sv
// Shared types and default geometry for the img2col line buffer
// and the mapping controller that drives it.
package im2col_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DONE
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int IMG_W_DEF  = 32;
    localparam int IMG_H_DEF  = 32;
    localparam int K_DEF      = 5;
    localparam int IDX_W_DEF  = 6;

endpackage

// File: rtl/im2col_row_mem.sv
// K x IMG_W pixel store: one write port, one read port with a
// registered read data output.
module im2col_row_mem #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int K      = 5,
    localparam int RW    = $clog2(K),
    localparam int CW    = $clog2(IMG_W)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [RW-1:0]     wr_row_i,
    input  logic [CW-1:0]     wr_col_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [RW-1:0]     rd_row_i,
    input  logic [CW-1:0]     rd_col_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [K][IMG_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_row_i][rd_col_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/im2col_row_buffer.sv
// Circular K-row line buffer between a raster pixel stream and the
// img2col mapping controller; each round release slides the window.
module im2col_row_buffer
    import im2col_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int K      = K_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              rd_valid_i,
    input  logic [IDX_W-1:0]  rd_round_i,
    input  logic [IDX_W-1:0]  rd_row_i,
    input  logic [IDX_W-1:0]  rd_pu_i,
    input  logic [IDX_W-1:0]  rd_col_i,
    input  logic              rd_last_i,
    output logic              rd_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [IDX_W-1:0]  out_pu_o,
    output logic              err_o,
    output logic              done_o
);

    localparam int RW = $clog2(K);
    localparam int CW = $clog2(IMG_W);
    localparam int SW = IDX_W + 1;

    localparam logic [SW-1:0] KS     = SW'(K);
    localparam logic [SW-1:0] HS     = SW'(IMG_H);
    localparam logic [SW-1:0] WS     = SW'(IMG_W);
    localparam logic [SW-1:0] ROUNDS = SW'(IMG_H - K + 1);

    state_e            state_q;
    logic [CW-1:0]     wr_col_q;
    logic [RW-1:0]     wr_phys_q;
    logic [RW-1:0]     base_phys_q;
    logic [SW-1:0]     rows_wr_q;
    logic [SW-1:0]     base_row_q;
    logic              out_valid_q;
    logic              zero_q;
    logic              err_q;
    logic              done_q;
    logic [IDX_W-1:0]  out_pu_q;

    logic              in_ready;
    logic              wr_fire;
    logic              wr_wrap;
    logic              rd_acc;
    logic              rel;
    logic              oob;
    logic [SW-1:0]     live_rows;
    logic [SW-1:0]     abs_row;
    logic [SW-1:0]     col_sum;
    logic [SW-1:0]     phys_sum;
    logic [RW-1:0]     rd_phys;
    logic [DATA_W-1:0] mem_rd;

    assign live_rows = rows_wr_q - base_row_q;
    assign in_ready  = (state_q == S_FILL || state_q == S_RUN)
                       && rows_wr_q < HS && live_rows < KS;
    assign wr_fire   = in_valid_i && in_ready;
    assign wr_wrap   = wr_col_q == CW'(IMG_W - 1);

    assign abs_row = {1'b0, rd_round_i} + {1'b0, rd_row_i};
    assign rd_acc  = state_q == S_RUN && rd_valid_i
                     && abs_row < rows_wr_q;
    assign rel     = rd_acc && rd_last_i;
    assign col_sum = {1'b0, rd_pu_i} + {1'b0, rd_col_i};
    assign oob     = rd_row_i >= IDX_W'(K) || rd_col_i >= IDX_W'(K)
                     || col_sum >= WS;

    // In-range rd_row keeps the sum below 2K, so one subtract wraps it.
    assign phys_sum = SW'(base_phys_q) + {1'b0, rd_row_i};
    assign rd_phys  = (phys_sum >= KS) ? RW'(phys_sum - KS)
                                       : RW'(phys_sum);

    im2col_row_mem #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .K      (K)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (wr_fire),
        .wr_row_i  (wr_phys_q),
        .wr_col_i  (wr_col_q),
        .wr_data_i (in_data_i),
        .rd_en_i   (rd_acc && !oob),
        .rd_row_i  (rd_phys),
        .rd_col_i  (CW'(col_sum)),
        .rd_data_o (mem_rd)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wr_col_q    <= '0;
            wr_phys_q   <= '0;
            base_phys_q <= '0;
            rows_wr_q   <= '0;
            base_row_q  <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            out_pu_q    <= '0;
        end else begin
            done_q      <= 1'b0;
            out_valid_q <= rd_acc;
            if (rd_acc) begin
                out_pu_q <= rd_pu_i;
                zero_q   <= oob;
                if (oob || {1'b0, rd_round_i} != base_row_q) begin
                    err_q <= 1'b1;
                end
            end
            if (wr_fire) begin
                if (wr_wrap) begin
                    wr_col_q  <= '0;
                    wr_phys_q <= (wr_phys_q == RW'(K - 1)) ? '0
                                 : wr_phys_q + 1'b1;
                    rows_wr_q <= rows_wr_q + 1'b1;
                end else begin
                    wr_col_q <= wr_col_q + 1'b1;
                end
            end
            if (rel) begin
                base_row_q  <= base_row_q + 1'b1;
                base_phys_q <= (base_phys_q == RW'(K - 1)) ? '0
                               : base_phys_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_FILL;
                        err_q       <= 1'b0;
                        wr_col_q    <= '0;
                        wr_phys_q   <= '0;
                        base_phys_q <= '0;
                        rows_wr_q   <= '0;
                        base_row_q  <= '0;
                    end
                end
                S_FILL: begin
                    if (rows_wr_q == KS) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rel && base_row_q + 1'b1 == ROUNDS) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready;
    assign rd_ready_o  = rd_acc;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = zero_q ? '0 : mem_rd;
    assign out_pu_o    = out_pu_q;
    assign err_o       = err_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_im2col_row_buffer.sv
// Directed bench for im2col_row_buffer with a pixel-array reference
// model checked against every output cycle.
module tb_im2col_row_buffer;

    localparam int IW = 32;
    localparam int IH = 32;
    localparam int KK = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       rd_valid = 1'b0;
    logic [5:0] rd_round = '0;
    logic [5:0] rd_row = '0;
    logic [5:0] rd_pu = '0;
    logic [5:0] rd_col = '0;
    logic       rd_last = 1'b0;
    logic       rd_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [5:0] out_pu;
    logic       err;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    int cur_img = 1;
    int done_cnt = 0;

    im2col_row_buffer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .rd_valid_i  (rd_valid),
        .rd_round_i  (rd_round),
        .rd_row_i    (rd_row),
        .rd_pu_i     (rd_pu),
        .rd_col_i    (rd_col),
        .rd_last_i   (rd_last),
        .rd_ready_o  (rd_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_pu_o    (out_pu),
        .err_o       (err),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    function automatic int pix(input int img, input int r, input int c);
        if (img == 1) return (r * 32 + c) & 255;
        return (r * 7 + c * 3 + 85) & 255;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: every accepted read must yield one beat next cycle.
    logic pending = 1'b0;
    int   exp_d;
    int   exp_pu;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (pending) begin
            chk("out_valid", int'(out_valid), 1);
            chk("out_data", int'(out_data), exp_d);
            chk("out_pu", int'(out_pu), exp_pu);
        end else begin
            chk("out_idle", int'(out_valid), 0);
        end
        pending = rd_valid && rd_ready && !rst;
        if (pending) begin
            exp_pu = int'(rd_pu);
            if (rd_row >= KK || rd_col >= KK || int'(rd_pu) + int'(rd_col) >= IW)
                exp_d = 0;
            else
                exp_d = pix(cur_img, int'(rd_round) + int'(rd_row),
                            int'(rd_pu) + int'(rd_col));
        end
    end

    task automatic push(input int v);
        int n;
        in_valid = 1'b1;
        in_data = 8'(v);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 5000) begin
                chk("push_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int rn, input int rw, input int pu,
                      input int cl, input logic last);
        int n;
        rd_valid = 1'b1;
        rd_round = 6'(rn);
        rd_row = 6'(rw);
        rd_pu = 6'(pu);
        rd_col = 6'(cl);
        rd_last = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (rd_ready) break;
            n++;
            if (n > 5000) begin
                chk("read_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        rd_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_rd_ready", int'(rd_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_pu", int'(out_pu), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic fill_rows(input int img, input int r0, input int r1);
        for (int r = r0; r < r1; r++)
            for (int c = 0; c < IW; c++)
                push(pix(img, r, c));
        in_valid = 1'b0;
    endtask

    initial begin
        do_reset();

        // Fill K rows and probe the window.
        cur_img = 1;
        pulse_start();
        fill_rows(1, 0, KK);
        repeat (2) @(negedge clk);
        chk("full_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rd(0, 2, 3, 4, 1'b0);
        rd_valid = 1'b0;
        @(negedge clk);
        chk("lit_0x47", int'(out_data), 8'h47);
        chk("lit_pu3", int'(out_pu), 3);
        chk("pre_rel_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rd(0, 0, 0, 0, 1'b1);
        rd_valid = 1'b0;
        rd_last = 1'b0;
        @(negedge clk);
        chk("post_rel_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Row 5 not yet present: read must stall until it lands.
        rd_valid = 1'b1;
        rd_round = 6'd1;
        rd_row = 6'd4;
        rd_pu = 6'd0;
        rd_col = 6'd0;
        repeat (3) @(negedge clk);
        chk("stall_rd_ready", int'(rd_ready), 0);
        @(posedge clk);
        #1;
        fork
            fill_rows(1, 5, 6);
            rd(1, 4, 0, 0, 1'b0);
        join
        rd_valid = 1'b0;
        @(negedge clk);
        chk("lit_0xA0", int'(out_data), 8'hA0);
        @(posedge clk);
        #1;

        // Abandon the image mid-run, then run a whole new one.
        do_reset();
        cur_img = 2;
        done_cnt = 0;
        pulse_start();
        fork
            fill_rows(2, 0, IH);
            begin
                rd(0, 1, 2, 3, 1'b0);
                rd_valid = 1'b0;
                @(negedge clk);
                chk("lit_new_img", int'(out_data), 8'h6B);
                @(posedge clk);
                #1;
                for (int rn = 0; rn <= IH - KK; rn++)
                    for (int rw = 0; rw < KK; rw++)
                        for (int pu = 0; pu <= IW - KK; pu++)
                            for (int cl = 0; cl < KK; cl++)
                                rd(rn, rw, pu, cl,
                                   rw == KK - 1 && pu == IW - KK && cl == KK - 1);
                rd_valid = 1'b0;
                rd_last = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("full_err", int'(err), 0);
        chk("idle_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;

        // Out-of-range column: zero data and sticky err.
        cur_img = 1;
        pulse_start();
        fill_rows(1, 0, KK);
        rd(0, 0, 30, 4, 1'b0);
        rd_valid = 1'b0;
        @(negedge clk);
        chk("oob_data", int'(out_data), 0);
        chk("oob_err", int'(err), 1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        rd(0, 1, 1, 1, 1'b0);
        rd_valid = 1'b0;
        @(negedge clk);
        chk("lit_0x22", int'(out_data), 8'h22);
        chk("err_sticky", int'(err), 1);
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
        chk("err_start_run", int'(err), 1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/im2col_row_buffer.md
Name: im2col_row_buffer

Overview:
- Circular line buffer that feeds the img2col mapping controller's consumers.
- Upstream: accepts a raster pixel stream, one pixel per beat.
- Downstream: takes (round, row, PU, column) indices from the mapping controller and returns the matching image pixel one cycle later.
- Holds K rows at a time. The oldest row is released when the mapping controller finishes a round, which slides the window down one image row.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 32, image width in pixels
- IMG_H, 32, image height in rows
- K, 5, kernel size; number of rows held
- IDX_W, 6, width of all index ports

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a new image
- in_valid  in  1  upstream pixel valid
- in_data  in  DATA_W  upstream pixel, raster order
- in_ready  out  1  buffer can accept a pixel this cycle
- rd_valid  in  1  mapping controller presents an index set
- rd_round  in  IDX_W  output row (0..IMG_H-K)
- rd_row  in  IDX_W  kernel row within window (0..K-1)
- rd_pu  in  IDX_W  PU number / output column (0..IMG_W-K)
- rd_col  in  IDX_W  kernel column (0..K-1)
- rd_last  in  1  final read of the current round; releases oldest row
- rd_ready  out  1  read accepted this cycle
- out_valid  out  1  out_data valid (one cycle after accepted read)
- out_data  out  DATA_W  pixel[rd_round+rd_row][rd_pu+rd_col]
- out_pu  out  IDX_W  rd_pu echoed, aligned with out_data
- err  out  1  sticky: out-of-range index accepted
- done  out  1  one-cycle pulse: all IMG_H-K+1 rounds released

Behaviour:
- Reset (sync, active-high, priority over everything):
  - state=IDLE; all counters and pointers cleared.
  - in_ready, rd_ready, out_valid, out_data, out_pu, err, done = 0.
  - Storage contents undefined. Reset mid-image abandons the image.
- States: IDLE, FILL, RUN, DONE.
  - IDLE: in_ready=0, rd_ready=0. start -> FILL, clears err.
  - FILL: in_ready=1. Reads are not accepted. -> RUN when rows_written==K.
  - RUN: writes and reads proceed concurrently.
    - -> DONE on the cycle base_row becomes IMG_H-K+1 (28 by default).
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Write side:
  - wr_col counts 0..IMG_W-1. On wrap, wr_phys advances mod K and rows_written increments.
  - in_ready = state in {FILL,RUN} and rows_written<IMG_H and (rows_written-base_row)<K.
  - in_ready derives only from registered state. A row freed in cycle t is writable from t+1.
- Read side:
  - Absolute row r = rd_round+rd_row.
  - rd_ready = state==RUN and rd_valid and r<rows_written.
  - When stalled, the mapping controller holds its indices stable.
  - Physical row = base_phys + rd_row, wrapped mod K by compare-subtract (no divider).
  - rd_round must equal base_row. A mismatch sets err.
- Latency: accepted read at cycle t gives out_valid=1 with out_data/out_pu at t+1. Registered memory read, no bubbles under back-to-back accepts.
- Release:
  - An accepted read with rd_last=1 increments base_row and base_phys (mod K) at end of cycle.
  - The read itself returns data from the pre-release window.
- Out-of-range: rd_row>=K, rd_col>=K, or rd_pu+rd_col>=IMG_W:
  - read is still accepted; out_data=0; err set (sticky until start).
- Simultaneous write to slot S and release of slot S in the same cycle cannot occur, because in_ready is registered-state based.
- Arithmetic:
  - Index sums are IDX_W+1 bits wide to avoid wrap.
  - rows_written and base_row are IDX_W+1 bits.

Decomposition:
- Package im2col_pkg holds:
  - state enum typedef (IDLE, FILL, RUN, DONE)
  - default IMG_W, IMG_H, K, IDX_W constants, shared with the mapping controller
- One sub-module: im2col_row_mem.
  - K×IMG_W×DATA_W single-write, single-read synchronous RAM.
  - Write port: wr_en, wr_row, wr_col, wr_data.
  - Read port: rd_en, rd_row, rd_col, registered rd_data.
- FSM, pointers and handshake stay in the top.

Test Plan:
- Reset, then start and 160 pixels of value (row*32+col)&0xFF -> state RUN after pixel 160; in_ready drops (5 rows held, none released).
- Read round 0, row 2, PU 3, col 4 -> out_data=0x47 (row 2, col 7) on the next cycle, out_pu=3.
- Read with rd_last=1 in round 0, then stream row 5 -> in_ready rises the cycle after release. A read of round 1, row 4, PU 0, col 0 stalls until pixel 5×32 is written, then returns 0xA0.
- Full image with a mapping-controller model issuing 28×5×28×5 reads -> every out_data matches the reference pixel, done pulses once after the 28th release, err=0.
- Read with rd_pu=30, rd_col=4 -> out_data=0, err=1 and held until the next start.
- Assert rst mid-RUN, then start and a new image -> first read returns the new image data; no stale pointers.
